// File: rtl/updown_digit_counter.sv
// Cascaded hex/BCD up/down digit counter with load, clear, terminal count, wrap pulse and sticky overflow.
// Count, wrap and ovf are registered and update on the sampled edge; tc is combinational; no backpressure.
module updown_digit_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  udc_clk,
  input  logic                  udc_rst_n,
  input  logic                  udc_en,
  input  logic                  udc_clr,
  input  logic                  udc_sel,
  input  logic                  udc_dir,
  input  logic                  udc_load,
  input  logic [4*DIGITS-1:0]   udc_din,
  output logic [4*DIGITS-1:0]   udc_q,
  output logic                  udc_tc,
  output logic                  udc_wrap,
  output logic                  udc_ovf
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]      cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  logic              ovf_q, ovf_d;

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_zero;
  logic [W-1:0]      step_val;
  logic [W-1:0]      load_val;
  logic [3:0]        dig;
  logic [3:0]        din_dig;
  logic [3:0]        dig_max;
  logic              carry;

  // Illegal BCD digits (10..15) behave as 9: they count as max and step down to 8.
  always_comb begin
    at_max   = '0;
    at_zero  = '0;
    step_val = '0;
    load_val = '0;
    dig      = '0;
    din_dig  = '0;
    dig_max  = udc_sel ? 4'd9 : 4'd15;
    carry    = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      dig        = cnt_q[4*k +: 4];
      din_dig    = udc_din[4*k +: 4];
      at_max[k]  = udc_sel ? (dig >= 4'd9) : (dig == 4'hF);
      at_zero[k] = (dig == 4'd0);
      load_val[4*k +: 4] = (udc_sel && (din_dig > 4'd9)) ? 4'd9 : din_dig;
      if (!carry) begin
        step_val[4*k +: 4] = dig;
      end else if (udc_dir) begin
        step_val[4*k +: 4] = at_max[k] ? 4'd0 : dig + 4'd1;
      end else if (at_zero[k]) begin
        step_val[4*k +: 4] = dig_max;
      end else begin
        step_val[4*k +: 4] = (udc_sel && (dig > 4'd9)) ? 4'd8 : dig - 4'd1;
      end
      carry = carry & (udc_dir ? at_max[k] : at_zero[k]);
    end
  end

  assign udc_tc = udc_en & (udc_dir ? (&at_max) : (&at_zero));

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    if (udc_clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (udc_load) begin
      cnt_d = load_val;
    end else if (udc_en) begin
      cnt_d  = step_val;
      wrap_d = udc_tc;
      ovf_d  = ovf_q | udc_tc;
    end
  end

  always_ff @(posedge udc_clk or negedge udc_rst_n) begin
    if (!udc_rst_n) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign udc_q    = cnt_q;
  assign udc_wrap = wrap_q;
  assign udc_ovf  = ovf_q;

endmodule
